// File: rtl/dca_matrix_load2mreg_mbuf.sv
// rtl/dca_matrix_load2mreg_mbuf.sv - multi-bank row-to-matrix loader with pad, transpose and overrun detect
module dca_matrix_load2mreg_mbuf #(
    parameter int MATRIX_SIZE      = 8,
    parameter int BW_TENSOR_SCALAR = 32,
    parameter int NUM_BANK         = 2,
    parameter logic [BW_TENSOR_SCALAR-1:0] PAD_VALUE = '0
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  clear,
    input  logic                                                  enable,
    output logic                                                  busy,
    input  logic                                                  cfg_transpose,
    output logic                                                  load_tensor_row_wready,
    input  logic                                                  load_tensor_row_wvalid,
    input  logic                                                  load_tensor_row_wlast,
    input  logic [MATRIX_SIZE*BW_TENSOR_SCALAR-1:0]               load_tensor_row_wdata,
    output logic                                                  loadreg_rready,
    input  logic                                                  loadreg_rrequest,
    output logic [MATRIX_SIZE*MATRIX_SIZE*BW_TENSOR_SCALAR-1:0]   loadreg_rdata,
    output logic                                                  loadreg_rtransposed,
    output logic                                                  overrun_error
);

    localparam int MAT_W = MATRIX_SIZE * MATRIX_SIZE * BW_TENSOR_SCALAR;
    localparam int CNT_W = $clog2(MATRIX_SIZE + 1);
    localparam int PTR_W = $clog2(NUM_BANK);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0]          bank_state [NUM_BANK];
    logic [MAT_W-1:0]    bank_mem   [NUM_BANK];
    logic [NUM_BANK-1:0] bank_trans;
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [CNT_W-1:0]    row_cnt;
    logic                fill_trans;
    logic                overrun_q;

    logic                wr_accept;
    logic                rd_accept;
    logic                first_beat;
    logic                beat_trans;
    logic                row_full;
    logic [MAT_W-1:0]    wr_matrix;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BANK - 1)) ? '0 : p + 1'b1;
    endfunction

    assign load_tensor_row_wready = enable & (bank_state[wptr] != ST_FULL);
    assign loadreg_rready         = enable & (bank_state[rptr] == ST_FULL);
    assign loadreg_rdata          = loadreg_rready ? bank_mem[rptr] : '0;
    assign loadreg_rtransposed    = loadreg_rready & bank_trans[rptr];
    assign overrun_error          = overrun_q;

    assign wr_accept  = load_tensor_row_wvalid & load_tensor_row_wready;
    assign rd_accept  = loadreg_rrequest & loadreg_rready;
    assign first_beat = (bank_state[wptr] == ST_EMPTY);
    // The transpose mode is latched on row 0, so later toggles cannot split a matrix.
    assign beat_trans = first_beat ? cfg_transpose : fill_trans;
    assign row_full   = (row_cnt == CNT_W'(MATRIX_SIZE));

    always_comb begin
        busy = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (bank_state[b] != ST_EMPTY) begin
                busy = 1'b1;
            end
        end
    end

    // A fresh bank starts from an all-pad image so undelivered rows read as PAD_VALUE.
    always_comb begin
        wr_matrix = first_beat ? {(MATRIX_SIZE*MATRIX_SIZE){PAD_VALUE}} : bank_mem[wptr];
        for (int r = 0; r < MATRIX_SIZE; r++) begin
            if (row_cnt == CNT_W'(r)) begin
                for (int c = 0; c < MATRIX_SIZE; c++) begin
                    if (beat_trans) begin
                        wr_matrix[(c*MATRIX_SIZE + r)*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] =
                            load_tensor_row_wdata[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR];
                    end else begin
                        wr_matrix[(r*MATRIX_SIZE + c)*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] =
                            load_tensor_row_wdata[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR];
                    end
                end
            end
        end
    end

    // Matrix storage carries no reset; the bank state alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_accept && !clear && !row_full) begin
            bank_mem[wptr] <= wr_matrix;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                bank_state[b] <= ST_EMPTY;
            end
            bank_trans <= '0;
            wptr       <= '0;
            rptr       <= '0;
            row_cnt    <= '0;
            fill_trans <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (clear) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                bank_state[b] <= ST_EMPTY;
            end
            bank_trans <= '0;
            wptr       <= '0;
            rptr       <= '0;
            row_cnt    <= '0;
            fill_trans <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // Read and write never target the same bank: one needs FULL, the other not FULL.
            if (rd_accept) begin
                bank_state[rptr] <= ST_EMPTY;
                rptr             <= ptr_next(rptr);
            end
            if (wr_accept) begin
                if (first_beat) begin
                    fill_trans <= cfg_transpose;
                end
                if (row_full) begin
                    overrun_q <= 1'b1;
                end
                if (load_tensor_row_wlast) begin
                    bank_state[wptr] <= ST_FULL;
                    bank_trans[wptr] <= beat_trans;
                    row_cnt          <= '0;
                    wptr             <= ptr_next(wptr);
                end else begin
                    bank_state[wptr] <= ST_FILLING;
                    if (!row_full) begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dca_matrix_load2mreg_mbuf.sv
// tb/tb_dca_matrix_load2mreg_mbuf.sv - self-checking bench for the multi-bank matrix loader
module tb_dca_matrix_load2mreg_mbuf;

    localparam int MS    = 4;
    localparam int BW    = 16;
    localparam int NB    = 2;
    localparam logic [BW-1:0] PAD = 16'hFFFF;
    localparam int ROW_W = MS * BW;
    localparam int MAT_W = MS * MS * BW;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             enable;
    logic             busy;
    logic             cfg_transpose;
    logic             wready;
    logic             wvalid;
    logic             wlast;
    logic [ROW_W-1:0] wdata;
    logic             rready;
    logic             rrequest;
    logic [MAT_W-1:0] rdata;
    logic             rtransposed;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    logic [ROW_W-1:0] stim_rows [0:7];
    logic [MAT_W-1:0] exp_q     [$];
    bit               exp_t_q   [$];

    dca_matrix_load2mreg_mbuf #(
        .MATRIX_SIZE      (MS),
        .BW_TENSOR_SCALAR (BW),
        .NUM_BANK         (NB),
        .PAD_VALUE        (PAD)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .clear                  (clear),
        .enable                 (enable),
        .busy                   (busy),
        .cfg_transpose          (cfg_transpose),
        .load_tensor_row_wready (wready),
        .load_tensor_row_wvalid (wvalid),
        .load_tensor_row_wlast  (wlast),
        .load_tensor_row_wdata  (wdata),
        .loadreg_rready         (rready),
        .loadreg_rrequest       (rrequest),
        .loadreg_rdata          (rdata),
        .loadreg_rtransposed    (rtransposed),
        .overrun_error          (overrun)
    );

    always #5 clk = ~clk;

    // Element (i,j): row i of the delivered rows, or row j read down column i when transposed.
    function automatic logic [MAT_W-1:0] model_matrix(input int n, input bit t);
        logic [MAT_W-1:0] m;
        logic [ROW_W-1:0] src;
        int nrows;
        nrows = (n > MS) ? MS : n;
        for (int i = 0; i < MS; i++) begin
            for (int j = 0; j < MS; j++) begin
                m[(i*MS + j)*BW +: BW] = PAD;
                if (!t && i < nrows) begin
                    src = stim_rows[i];
                    m[(i*MS + j)*BW +: BW] = src[j*BW +: BW];
                end else if (t && j < nrows) begin
                    src = stim_rows[j];
                    m[(i*MS + j)*BW +: BW] = src[i*BW +: BW];
                end
            end
        end
        return m;
    endfunction

    task automatic send_beat(input logic [ROW_W-1:0] d, input bit last, input bit t);
        int waitc = 0;
        wvalid = 1'b1;
        wdata = d;
        wlast = last;
        cfg_transpose = t;
        while (wready !== 1'b1 && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        if (wready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wready_timeout: wready=%b required 1", wready);
        end
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic send_matrix(input int n, input bit t, input bit toggle);
        for (int b = 0; b < n; b++) begin
            send_beat(stim_rows[b], b == n - 1, (toggle && b > 0) ? ~t : t);
        end
        exp_q.push_back(model_matrix(n, t));
        exp_t_q.push_back(t);
    endtask

    task automatic randomize_rows();
        for (int b = 0; b < 8; b++) begin
            stim_rows[b] = {$urandom, $urandom};
        end
    endtask

    task automatic read_matrix(input string name);
        int waitc = 0;
        logic [MAT_W-1:0] em;
        bit et;
        while (rready !== 1'b1 && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        checks++;
        if (rready !== 1'b1 || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_rready: rready=%b pending=%0d required rready 1 with a pending matrix",
                     name, rready, exp_q.size());
        end else begin
            em = exp_q.pop_front();
            et = exp_t_q.pop_front();
            if (rdata !== em) begin
                failures++;
                $display("FAIL %s_rdata: got %h required %h", name, rdata, em);
            end
            checks++;
            if (rtransposed !== et) begin
                failures++;
                $display("FAIL %s_rtransposed: got %b required %b", name, rtransposed, et);
            end
        end
        rrequest = 1'b1;
        @(posedge clk);
        #1;
        rrequest = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, wready, rready, rtransposed, overrun} !== 5'b0 || rdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b wready=%b rready=%b rt=%b ovr=%b rdata=%h required all 0",
                     busy, wready, rready, rtransposed, overrun, rdata);
        end
        rst = 1'b0;
        enable = 1'b1;
        #1;
        checks++;
        if (wready !== 1'b1) begin
            failures++;
            $display("FAIL reset_wready: got %b required 1", wready);
        end
    endtask

    task automatic test_single();
        logic [ROW_W-1:0] row;
        for (int r = 0; r < MS; r++) begin
            for (int c = 0; c < MS; c++) begin
                row[c*BW +: BW] = BW'(r*16 + c);
            end
            stim_rows[r] = row;
        end
        for (int b = 0; b < MS; b++) begin
            send_beat(stim_rows[b], b == MS - 1, 1'b0);
            if (b == MS - 2) begin
                checks++;
                if (rready !== 1'b0) begin
                    failures++;
                    $display("FAIL single_early_rready: got %b required 0", rready);
                end
            end
        end
        exp_q.push_back(model_matrix(MS, 1'b0));
        exp_t_q.push_back(1'b0);
        checks++;
        if (rready !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: rready=%b required 1", rready);
        end
        checks++;
        if (rdata[(2*MS + 1)*BW +: BW] !== 16'h0021) begin
            failures++;
            $display("FAIL single_elem21: got %h required 0021", rdata[(2*MS + 1)*BW +: BW]);
        end
        read_matrix("single");
        checks++;
        if (rready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_after_read: rready=%b busy=%b required 0 0", rready, busy);
        end
    endtask

    task automatic test_pad();
        randomize_rows();
        send_matrix(2, 1'b0, 1'b0);
        checks++;
        if (rdata[MAT_W-1:2*ROW_W] !== {(2*MS){PAD}}) begin
            failures++;
            $display("FAIL pad_rows: got %h required all ffff", rdata[MAT_W-1:2*ROW_W]);
        end
        read_matrix("pad");
        randomize_rows();
        send_matrix(1, 1'b0, 1'b0);
        read_matrix("single_beat");
    endtask

    task automatic test_transpose();
        logic [ROW_W-1:0] row;
        logic [MAT_W-1:0] want;
        for (int r = 0; r < MS; r++) begin
            for (int c = 0; c < MS; c++) begin
                row[c*BW +: BW] = BW'(r);
            end
            stim_rows[r] = row;
        end
        for (int i = 0; i < MS; i++) begin
            for (int j = 0; j < MS; j++) begin
                want[(i*MS + j)*BW +: BW] = BW'(j);
            end
        end
        send_matrix(MS, 1'b1, 1'b1);
        checks++;
        if (rdata !== want) begin
            failures++;
            $display("FAIL transpose_elems: got %h required %h", rdata, want);
        end
        read_matrix("transpose");
    endtask

    task automatic test_back_to_back();
        for (int m = 0; m < 2; m++) begin
            randomize_rows();
            send_matrix(MS, m[0], 1'b0);
        end
        checks++;
        if (wready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full: wready=%b busy=%b required 0 1", wready, busy);
        end
        read_matrix("b2b_m1");
        checks++;
        if (wready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wready_after_read: got %b required 1", wready);
        end
        randomize_rows();
        send_matrix(3, 1'b1, 1'b0);
        read_matrix("b2b_m2");
        read_matrix("b2b_m3");
    endtask

    task automatic test_overrun();
        randomize_rows();
        for (int b = 0; b < 6; b++) begin
            send_beat(stim_rows[b], b == 5, 1'b0);
            if (b == MS - 1) begin
                checks++;
                if (overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_early: got %b required 0", overrun);
                end
            end
            if (b == MS) begin
                checks++;
                if (overrun !== 1'b1) begin
                    failures++;
                    $display("FAIL overrun_set: got %b required 1", overrun);
                end
            end
        end
        exp_q.push_back(model_matrix(6, 1'b0));
        exp_t_q.push_back(1'b0);
        read_matrix("overrun");
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got %b required 1", overrun);
        end
        randomize_rows();
        send_matrix(2, 1'b0, 1'b0);
        do_clear();
        checks++;
        if (overrun !== 1'b0 || rready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_state: ovr=%b rready=%b busy=%b required 0 0 0", overrun, rready, busy);
        end
    endtask

    task automatic test_reset_midfill();
        randomize_rows();
        send_beat(stim_rows[0], 1'b0, 1'b0);
        send_beat(stim_rows[1], 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rready !== 1'b0 || rdata !== '0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_midfill: busy=%b rready=%b ovr=%b required 0 0 0", busy, rready, overrun);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_enable();
        randomize_rows();
        send_matrix(3, 1'b1, 1'b0);
        enable = 1'b0;
        #1;
        checks++;
        if (rready !== 1'b0 || wready !== 1'b0 || rdata !== '0) begin
            failures++;
            $display("FAIL enable_stall: rready=%b wready=%b required 0 0", rready, wready);
        end
        rrequest = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rrequest = 1'b0;
        enable = 1'b1;
        read_matrix("enable_resume");
    endtask

    task automatic test_random();
        int k;
        int n;
        bit t;
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(1, NB);
            for (int m = 0; m < k; m++) begin
                randomize_rows();
                n = $urandom_range(1, MS);
                t = 1'($urandom);
                send_matrix(n, t, 1'($urandom));
            end
            for (int m = 0; m < k; m++) begin
                read_matrix("random");
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        enable = 1'b0;
        cfg_transpose = 1'b0;
        wvalid = 1'b0;
        wlast = 1'b0;
        wdata = '0;
        rrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_pad();
        test_transpose();
        test_back_to_back();
        test_overrun();
        test_reset_midfill();
        test_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dca_matrix_load2mreg_mbuf.md
Name: dca_matrix_load2mreg_mbuf

Overview:
- Next-generation load-to-matrix-register stage for the DCA matrix unit.
- Accepts tensor rows from the matrix LSU load stream over a valid/ready handshake and assembles them into complete MATRIX_SIZE x MATRIX_SIZE matrices.
- Holds matrices in NUM_BANK ping-pong banks so loading of matrix N+1 overlaps consumption of matrix N by the step controller.
- Adds three behaviours to the single-buffer loader: short-matrix zero padding, an optional per-matrix transpose on write, and a sticky overrun flag.

Parameters:
- MATRIX_SIZE, 8, rows and columns per matrix (2..16).
- BW_TENSOR_SCALAR, 32, bits per element.
- NUM_BANK, 2, number of matrix banks (2..4).
- PAD_VALUE, 0, element value written into rows not delivered before wlast.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous flush: empties all banks and aborts any fill in progress.
- enable  in  1  when low, both handshakes are stalled (wready=0, rready=0); stored state is held.
- busy  out  1  high when any bank is FILLING or FULL.
- cfg_transpose  in  1  transpose mode; sampled on the first row beat of each matrix.
- load_tensor_row_wready  out  1  row sink ready.
- load_tensor_row_wvalid  in  1  row beat valid.
- load_tensor_row_wlast  in  1  last row of the current matrix.
- load_tensor_row_wdata  in  MATRIX_SIZE*BW_TENSOR_SCALAR  one row; element 0 in the LSBs.
- loadreg_rready  out  1  a complete matrix is available.
- loadreg_rrequest  in  1  consume the head matrix.
- loadreg_rdata  out  MATRIX_SIZE*MATRIX_SIZE*BW_TENSOR_SCALAR  head matrix, row-major, element (0,0) in the LSBs.
- loadreg_rtransposed  out  1  transpose flag captured with the head matrix.
- overrun_error  out  1  sticky; set when a row arrives after MATRIX_SIZE rows without wlast.

Behaviour:
- Reset values: all banks EMPTY, write and read pointers 0, row counter 0, all outputs 0 (loadreg_rdata 0, overrun_error 0).
- Bank states: EMPTY -> FILLING on the first accepted beat; FILLING -> FULL on an accepted beat with wlast=1; FULL -> EMPTY on a read accept.
- Write pointer (wptr) selects the fill bank; read pointer (rptr) selects the head bank. Both wrap modulo NUM_BANK.
- Write handshake:
  - wready = enable & (bank[wptr] != FULL).
  - A beat is accepted when wvalid & wready.
  - Accepted row r is written into bank[wptr]: into row r when transpose=0, into column r when transpose=1.
  - The row counter increments on each accepted beat.
- On entering FILLING, every element of the bank is first preset to PAD_VALUE in the same cycle as the row-0 write. Rows r..MATRIX_SIZE-1 not delivered before wlast therefore read as PAD_VALUE (columns, in transpose mode).
- On an accepted wlast beat:
  - bank becomes FULL;
  - row counter resets to 0;
  - wptr advances;
  - the transpose flag is stored per bank.
- Overrun: an accepted beat with the row counter already at MATRIX_SIZE sets overrun_error. The data is dropped, the counter saturates, and the bank stays FILLING until wlast.
- A single-beat matrix (wlast on row 0) is legal: row 0 holds the data, all other rows are PAD_VALUE.
- Read handshake:
  - loadreg_rready = enable & (bank[rptr] == FULL).
  - loadreg_rdata and loadreg_rtransposed combinationally reflect bank[rptr]; they are 0 when rready=0.
  - A matrix is accepted when rrequest & rready. The bank becomes EMPTY and rptr advances on the next edge.
  - rrequest while rready=0 is ignored.
- Latency: a matrix completed by a wlast beat at edge N shows rready=1 after edge N (one cycle after the beat).
- Simultaneous events:
  - A write to bank[wptr] and a read of bank[rptr] in the same cycle are independent when the banks differ.
  - When all banks are FULL, wready=0. A read accept in that cycle frees the bank, and wready rises the following cycle; there is no same-cycle bypass.
- clear: all banks EMPTY, pointers and row counter 0, overrun_error 0. clear takes priority over same-cycle handshakes. Outputs reach their reset values after the edge.
- Asserting rst mid-fill discards the partial matrix asynchronously.
- Storage is NUM_BANK*MATRIX_SIZE^2*BW_TENSOR_SCALAR flops. No RAM macro is used.

Test Plan:
- Single matrix: MATRIX_SIZE=4, 4 rows with values r*16+c, wlast on row 3, transpose=0 -> rready=1 one cycle after the last beat; element (2,1)=0x21; after one rrequest, rready=0 and busy=0.
- Short matrix + pad: PAD_VALUE=0xFFFF, 2 rows then wlast -> rows 2..3 all 0xFFFF; rtransposed=0.
- Transpose: transpose=1, row r = {r,r,r,r} -> element (i,j)=j; rtransposed=1. Toggling cfg_transpose mid-matrix has no effect on that matrix.
- Back-to-back / full: NUM_BANK=2, three matrices sent with rrequest held low -> wready=0 after matrix 2 completes. Pulsing rrequest once -> wready=1 on the next cycle; matrix 3 lands in bank 0 and is read third, in order.
- Overrun: 5 rows without wlast at MATRIX_SIZE=4, then wlast -> overrun_error=1 stays set; the 5th row's data is absent from the matrix. clear -> overrun_error=0, rready=0.
- Reset/enable: rst asserted mid-fill -> all outputs 0 immediately. enable=0 with a full bank -> rready=0, wready=0, contents preserved and visible again when enable=1.
